// File: rtl/simd_alu_adder_sched.sv
// Round-robin scheduler that feeds one shared combinational SIMD adder from two requesters.
// Optional per-requester accept counters are enabled with SIMD_ADDER_SCHED_STATS_EN.
//
// state | meaning
// IDLE  | arbitrate between req0/req1 and accept the winner into add_*
// EXEC  | adder is evaluating the registered operands; result captured at end of cycle
// RESP  | rsp_* valid and held until the consumer accepts it
module simd_alu_adder_sched #(
    parameter int SIMD_DATA_WIDTH            = 256,
    parameter int SIMD_ADDER_DATA_MODE_WIDTH = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
`ifdef SIMD_ADDER_SCHED_STATS_EN
    input  logic                                  stat_clr,
    output logic [15:0]                           stat_cnt0,
    output logic [15:0]                           stat_cnt1,
`endif
    input  logic                                  req0_valid,
    output logic                                  req0_ready,
    input  logic [SIMD_DATA_WIDTH-1:0]            req0_a,
    input  logic [SIMD_DATA_WIDTH-1:0]            req0_b,
    input  logic [SIMD_ADDER_DATA_MODE_WIDTH-1:0] req0_mode,
    input  logic                                  req0_signed,
    input  logic                                  req1_valid,
    output logic                                  req1_ready,
    input  logic [SIMD_DATA_WIDTH-1:0]            req1_a,
    input  logic [SIMD_DATA_WIDTH-1:0]            req1_b,
    input  logic [SIMD_ADDER_DATA_MODE_WIDTH-1:0] req1_mode,
    input  logic                                  req1_signed,
    output logic [SIMD_DATA_WIDTH-1:0]            add_a,
    output logic [SIMD_DATA_WIDTH-1:0]            add_b,
    output logic [SIMD_ADDER_DATA_MODE_WIDTH-1:0] add_mode,
    output logic                                  add_signed,
    input  logic [SIMD_DATA_WIDTH-1:0]            add_result,
    output logic                                  rsp_valid,
    input  logic                                  rsp_ready,
    output logic [SIMD_DATA_WIDTH-1:0]            rsp_result,
    output logic                                  rsp_src,
    output logic                                  rsp_err
);

    localparam logic [SIMD_ADDER_DATA_MODE_WIDTH-1:0] MODE_MAX = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   last_grant;
    logic   winner;
    logic   req_any;
    logic   accept;

    // On a tie the requester that did not win last time goes next.
    assign req_any = req0_valid | req1_valid;
    assign winner  = (req0_valid & req1_valid) ? ~last_grant : ~req0_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (req_any) begin
                    accept    = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                if (rsp_valid & rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign req0_ready = accept & ~winner;
    assign req1_ready = accept & winner;

    // add_* only change on accept so the adder sees stable operands through EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            add_a      <= '0;
            add_b      <= '0;
            add_mode   <= '0;
            add_signed <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_src    <= 1'b0;
            rsp_err    <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            if (accept) begin
                add_a      <= winner ? req1_a      : req0_a;
                add_b      <= winner ? req1_b      : req0_b;
                add_mode   <= winner ? req1_mode   : req0_mode;
                add_signed <= winner ? req1_signed : req0_signed;
                rsp_src    <= winner;
                last_grant <= winner;
            end
            if (state == EXEC) begin
                rsp_result <= add_result;
                rsp_err    <= (add_mode > MODE_MAX);
                rsp_valid  <= 1'b1;
            end
            if ((state == RESP) && rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef SIMD_ADDER_SCHED_STATS_EN
    // Saturating accept counters; a clear wins over a same-cycle accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_cnt0 <= '0;
            stat_cnt1 <= '0;
        end else if (stat_clr) begin
            stat_cnt0 <= '0;
            stat_cnt1 <= '0;
        end else begin
            if (req0_ready && (stat_cnt0 != 16'hFFFF)) begin
                stat_cnt0 <= stat_cnt0 + 16'd1;
            end
            if (req1_ready && (stat_cnt1 != 16'hFFFF)) begin
                stat_cnt1 <= stat_cnt1 + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_simd_alu_adder_sched.sv
// Directed bench for simd_alu_adder_sched with a behavioural lane adder on the add_* port.
// Counter checks are compiled in when SIMD_ADDER_SCHED_STATS_EN is defined.
module tb_simd_alu_adder_sched;

    localparam int W  = 256;
    localparam int MW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_ready, req0_signed;
    logic          req1_valid, req1_ready, req1_signed;
    logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
    logic [MW-1:0] req0_mode, req1_mode;
    logic [W-1:0]  add_a, add_b, add_result;
    logic [MW-1:0] add_mode;
    logic          add_signed;
    logic          rsp_valid, rsp_ready, rsp_src, rsp_err;
    logic [W-1:0]  rsp_result;
`ifdef SIMD_ADDER_SCHED_STATS_EN
    logic          stat_clr;
    logic [15:0]   stat_cnt0, stat_cnt1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    simd_alu_adder_sched #(
        .SIMD_DATA_WIDTH           (W),
        .SIMD_ADDER_DATA_MODE_WIDTH(MW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef SIMD_ADDER_SCHED_STATS_EN
        .stat_clr   (stat_clr),
        .stat_cnt0  (stat_cnt0),
        .stat_cnt1  (stat_cnt1),
`endif
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_mode  (req0_mode),
        .req0_signed(req0_signed),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_mode  (req1_mode),
        .req1_signed(req1_signed),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_mode   (add_mode),
        .add_signed (add_signed),
        .add_result (add_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_src    (rsp_src),
        .rsp_err    (rsp_err)
    );

    // Wrap-around lane adder; unsupported modes return 0.
    function automatic logic [W-1:0] adder_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                                 input logic [MW-1:0] mode);
        logic [W-1:0] r;
        r = '0;
        if (mode == 2'd0) begin
            for (int i = 0; i < W / 8; i++) r[i*8 +: 8] = a[i*8 +: 8] + b[i*8 +: 8];
        end else if (mode == 2'd1) begin
            for (int i = 0; i < W / 16; i++) r[i*16 +: 16] = a[i*16 +: 16] + b[i*16 +: 16];
        end
        return r;
    endfunction

    always_comb add_result = adder_model(add_a, add_b, add_mode);

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic src);
        req0_valid = ~src;
        req1_valid = src;
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        step();
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_mode = '0; req0_signed = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_mode = '0; req1_signed = 1'b0;
        rsp_ready = 1'b0;
`ifdef SIMD_ADDER_SCHED_STATS_EN
        stat_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp_valid", W'(rsp_valid), W'(0));
        check("rst_add_a", add_a, '0);
        check("rst_rsp_result", rsp_result, '0);
        check("rst_rsp_src", W'(rsp_src), W'(0));
        rst = 1'b0;
        step();

        // 8-bit unsigned from req0
        req0_valid = 1'b1; req0_a = {32{8'hF0}}; req0_b = {32{8'h20}}; req0_mode = 2'd0; req0_signed = 1'b0;
        #1;
        check("t1_req0_ready", W'(req0_ready), W'(1));
        check("t1_req1_ready", W'(req1_ready), W'(0));
        step();
        req0_valid = 1'b0;
        check("t1_add_a", add_a, {32{8'hF0}});
        check("t1_exec_valid", W'(rsp_valid), W'(0));
        step();
        check("t1_rsp_valid", W'(rsp_valid), W'(1));
        check("t1_rsp_result", rsp_result, {32{8'h10}});
        check("t1_rsp_src", W'(rsp_src), W'(0));
        check("t1_rsp_err", W'(rsp_err), W'(0));
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("t1_hs_valid", W'(rsp_valid), W'(0));
        check("t1_hs_result_kept", rsp_result, {32{8'h10}});

        // 16-bit signed from req1
        req1_valid = 1'b1; req1_a = {16{16'h8000}}; req1_b = {16{16'hFFFF}}; req1_mode = 2'd1; req1_signed = 1'b1;
        #1;
        check("t2_req1_ready", W'(req1_ready), W'(1));
        check("t2_req0_ready", W'(req0_ready), W'(0));
        step();
        req1_valid = 1'b0;
        check("t2_add_mode", W'(add_mode), W'(1));
        check("t2_add_signed", W'(add_signed), W'(1));
        step();
        check("t2_rsp_result", rsp_result, {16{16'h7FFF}});
        check("t2_rsp_src", W'(rsp_src), W'(1));
        rsp_ready = 1'b1;
        step();

        // Fairness from reset, rsp_ready tied high
        rst = 1'b1; #1; rst = 1'b0;
        step();
        req0_a = {32{8'h01}}; req0_b = {32{8'h02}}; req0_mode = 2'd0; req0_signed = 1'b0;
        req1_a = {16{16'h1234}}; req1_b = {16{16'h1111}}; req1_mode = 2'd1; req1_signed = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("fair_req0_ready", W'(req0_ready), W'(i % 2 == 0));
            check("fair_req1_ready", W'(req1_ready), W'(i % 2 == 1));
            check("fair_both_ready", W'(req0_ready & req1_ready), W'(0));
            step();
            check("fair_exec_readys", W'(req0_ready | req1_ready), W'(0));
            step();
            check("fair_rsp_valid", W'(rsp_valid), W'(1));
            check("fair_rsp_src", W'(rsp_src), W'(i % 2));
            check("fair_rsp_result", rsp_result, (i % 2 == 1) ? {16{16'h2345}} : {32{8'h03}});
            step();
        end

        // Backpressure: both still valid, last grant was req1 so req0 wins
        rsp_ready = 1'b0;
        #1;
        check("bp_req0_ready", W'(req0_ready), W'(1));
        step();
        step();
        check("bp_rsp_valid", W'(rsp_valid), W'(1));
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold_valid", W'(rsp_valid), W'(1));
            check("bp_hold_result", rsp_result, {32{8'h03}});
            check("bp_hold_src", W'(rsp_src), W'(0));
            check("bp_hold_readys", W'(req0_ready | req1_ready), W'(0));
        end
        rsp_ready = 1'b1;
        step();
        check("bp_after_hs_valid", W'(rsp_valid), W'(0));
        check("bp_next_accept_req1", W'(req1_ready), W'(1));
        req0_valid = 1'b0;
        step();
        req1_valid = 1'b0;
        step();
        check("bp_next_src", W'(rsp_src), W'(1));
        check("bp_next_result", rsp_result, {16{16'h2345}});
        step();

        // Unsupported mode
        req0_valid = 1'b1; req0_a = {32{8'h11}}; req0_b = {32{8'h22}}; req0_mode = 2'd2;
        step();
        req0_valid = 1'b0;
        step();
        check("bad_rsp_valid", W'(rsp_valid), W'(1));
        check("bad_rsp_result", rsp_result, '0);
        check("bad_rsp_err", W'(rsp_err), W'(1));
        step();

        // Reset while an op from req1 is in EXEC
        req1_valid = 1'b1; req1_a = {32{8'h01}}; req1_b = {32{8'h02}}; req1_mode = 2'd0;
        step();
        req1_valid = 1'b0;
        check("rx_pre_src", W'(rsp_src), W'(1));
        rst = 1'b1;
        #1;
        check("rx_rsp_valid", W'(rsp_valid), W'(0));
        check("rx_add_a", add_a, '0);
        check("rx_rsp_err", W'(rsp_err), W'(0));
        check("rx_rsp_src", W'(rsp_src), W'(0));
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rx_no_rsp", W'(rsp_valid), W'(0));
        end
        req0_mode = 2'd0; req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("rx_tie_req0", W'(req0_ready), W'(1));
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();

`ifdef SIMD_ADDER_SCHED_STATS_EN
        check("st_rst_cnt0", W'(stat_cnt0), W'(0));
        issue(1'b0);
        issue(1'b0);
        issue(1'b1);
        issue(1'b0);
        check("st_cnt0", W'(stat_cnt0), W'(3));
        check("st_cnt1", W'(stat_cnt1), W'(1));
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        check("st_clr_cnt0", W'(stat_cnt0), W'(0));
        check("st_clr_cnt1", W'(stat_cnt1), W'(0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/simd_alu_adder_sched.md
Name: simd_alu_adder_sched

Overview:
- Round-robin scheduler sharing one combinational simd_alu_adder_top instance between two requesters.
- Accepts an operation from the winning requester and registers its operands onto the adder input ports.
- Captures the adder result into an output register and holds it until the consumer accepts it.
- Sits between the two issue ports (req0/req1) and the writeback path; one operation in flight at a time.

Parameters:
- SIMD_DATA_WIDTH, 256, lane-packed operand/result width; must be a multiple of 16.
- SIMD_ADDER_DATA_MODE_WIDTH, 2, width of data_mode (0 = 8-bit lanes, 1 = 16-bit lanes, others unsupported).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- reqN_valid  in  1  requester N (N=0,1) has an operation.
- reqN_ready  out  1  requester N accepted this cycle.
- reqN_a  in  SIMD_DATA_WIDTH  operand a.
- reqN_b  in  SIMD_DATA_WIDTH  operand b.
- reqN_mode  in  SIMD_ADDER_DATA_MODE_WIDTH  lane mode.
- reqN_signed  in  1  signed lanes.
- add_a  out  SIMD_DATA_WIDTH  registered operand a, to the adder.
- add_b  out  SIMD_DATA_WIDTH  registered operand b, to the adder.
- add_mode  out  SIMD_ADDER_DATA_MODE_WIDTH  registered mode, to the adder.
- add_signed  out  1  registered signedness, to the adder.
- add_result  in  SIMD_DATA_WIDTH  adder result, combinational from add_*.
- rsp_valid  out  1  response register holds a result.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  SIMD_DATA_WIDTH  registered result.
- rsp_src  out  1  index of the requester that issued the operation.
- rsp_err  out  1  issued mode was unsupported (>1).

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-high.
- Reset values: all outputs 0, FSM in IDLE, last_grant = 1 (req0 wins the first tie).
- FSM states: IDLE, EXEC, RESP.
- IDLE, arbitration:
  - If only one reqN_valid is high, that requester wins.
  - If both are high, the requester != last_grant wins.
  - If neither is high, stay in IDLE.
- IDLE, accept:
  - reqN_ready = (state==IDLE) & winner==N, combinational. At most one ready is high per cycle.
  - On accept, latch reqN_a/b/mode/signed into add_* and set rsp_src = N, last_grant = N; go to EXEC.
- EXEC (exactly one cycle):
  - rsp_result <= add_result; rsp_err <= (add_mode > 1); rsp_valid <= 1; go to RESP.
  - An unsupported mode yields rsp_result = 0 (the adder returns 0) with rsp_err = 1.
- RESP:
  - Hold rsp_* stable while rsp_ready is low.
  - On rsp_valid & rsp_ready: rsp_valid <= 0 and go to IDLE.
  - rsp_result, rsp_src and rsp_err keep their values after the handshake.
- Timing:
  - Latency: accept at cycle T, rsp_valid high from T+2.
  - Minimum issue interval is 3 cycles, with rsp_ready tied high.
- add_* hold their values outside IDLE-accept cycles. The adder inputs change only on accept.
- Requesters must not make reqN_valid depend on reqN_ready.
- A requester may drop reqN_valid before being accepted; no operation is issued for it.
- Lane arithmetic is performed entirely by the adder: per-lane wrap-around, no carry across lanes, no saturation.
- Reset asserted in any state returns everything to reset values immediately; an in-flight operation is lost.
- No request is accepted while in EXEC or RESP.
- Starvation bound: a continuously valid requester is accepted within 2 grants.

Optional Feature:
- Macro: SIMD_ADDER_SCHED_STATS_EN.
- Defined: adds outputs stat_cnt0 and stat_cnt1, 16 bits each.
  - stat_cntN increments on each accept from requester N and saturates at 16'hFFFF.
  - Both counters reset to 0.
  - An extra input stat_clr (1 bit, synchronous) zeroes both counters. stat_clr has priority over a same-cycle increment.
- Undefined: no counters and no stat_* ports; behaviour is otherwise identical.

Test Plan:
- Reset, 8-bit unsigned: req0 valid, a lanes=8'hF0, b lanes=8'h20, mode=0, signed=0 -> req0_ready at T; at T+2 rsp_valid=1, every 8-bit lane=8'h10, rsp_src=0, rsp_err=0.
- 16-bit signed: req1, a lanes=16'h8000, b lanes=16'hFFFF, mode=1, signed=1 -> rsp_result lanes=16'h7FFF, rsp_src=1.
- Fairness: both valid continuously for 4 operations from reset -> grant order 0,1,0,1; rsp_src sequence 0,1,0,1; never both readys high.
- Backpressure: rsp_ready low for 5 cycles after rsp_valid -> rsp_* stable, both readys low; the next accept occurs one cycle after the rsp handshake.
- Unsupported mode: mode=2 -> rsp_result=0, rsp_err=1. Then reset pulse while in EXEC -> all outputs 0 and FSM in IDLE, with rsp_valid never asserted for that op.
- With SIMD_ADDER_SCHED_STATS_EN: 3 req0 ops and 1 req1 op -> stat_cnt0=3, stat_cnt1=1. Then stat_clr -> both 0.
